// File: rtl/cnt32_sched.sv
// Round-robin job scheduler that shares one counter between two requesters:
// optional preload, N enabled count cycles, result capture. Optional macro: CNT_SCHED_RCO_STOP_EN.
module cnt32_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       mode0,
    input  logic [1:0]       mode1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             pre0,
    input  logic             pre1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             rco_seen,
    output logic             busy,
    output logic             enable_,
    output logic [1:0]       mode_,
    output logic [WIDTH-1:0] D_,
    input  logic [WIDTH-1:0] Q_,
    input  logic             rco_,
    input  logic             load_
);

    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic               last_q, last_d;
    logic [1:0]         job_mode_q, job_mode_d;
    logic [WIDTH-1:0]   job_data_q, job_data_d;
    logic [LEN_W-1:0]   job_len_q, job_len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic               done0_q, done0_d, done1_q, done1_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               rco_seen_q, rco_seen_d;
    logic               busy_q, busy_d;
    logic               enable_q, enable_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               pick;
    logic               pre_sel;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            job_mode_q <= '0;
            job_data_q <= '0;
            job_len_q  <= '0;
            cnt_q      <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            result_q   <= '0;
            rco_seen_q <= 1'b0;
            busy_q     <= 1'b0;
            enable_q   <= 1'b0;
            mode_q     <= 2'b00;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            job_mode_q <= job_mode_d;
            job_data_q <= job_data_d;
            job_len_q  <= job_len_d;
            cnt_q      <= cnt_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            result_q   <= result_d;
            rco_seen_q <= rco_seen_d;
            busy_q     <= busy_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            dout_q     <= dout_d;
        end
    end

    // Next-state, arbitration and job sequencing
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        job_mode_d = job_mode_q;
        job_data_d = job_data_q;
        job_len_d  = job_len_q;
        cnt_d      = cnt_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        result_d   = result_q;
        rco_seen_d = rco_seen_q;
        pick       = 1'b0;
        pre_sel    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last wins
                    pick       = (req0 && req1) ? ~last_q : req1;
                    sel_d      = pick;
                    job_mode_d = pick ? mode1 : mode0;
                    job_data_d = pick ? d1 : d0;
                    job_len_d  = pick ? len1 : len0;
                    pre_sel    = pick ? pre1 : pre0;
                    gnt0_d     = ~pick;
                    gnt1_d     = pick;
                    rco_seen_d = 1'b0;
                    if (pre_sel || job_mode_d == MODE_LOAD) begin
                        state_d = LOAD;
                    end else if (job_len_d == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        cnt_d   = job_len_d;
                    end
                end
            end
            LOAD: begin
                if (job_mode_q == MODE_LOAD || job_len_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                    cnt_d   = job_len_q;
                end
            end
            RUN: begin
                cnt_d = cnt_q - LEN_W'(1);
                if (rco_) begin
                    rco_seen_d = 1'b1;
                end
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end
`ifdef CNT_SCHED_RCO_STOP_EN
                if (rco_) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                result_d = Q_;
                done0_d  = ~sel_q;
                done1_d  = sel_q;
                last_d   = sel_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter controls follow the state being entered so they line up with it
    always_comb begin
        enable_d = 1'b0;
        mode_d   = mode_q;
        dout_d   = dout_q;
        busy_d   = (state_d != IDLE);
        case (state_d)
            LOAD: begin
                enable_d = 1'b1;
                mode_d   = MODE_LOAD;
                dout_d   = job_data_d;
            end
            RUN: begin
                enable_d = 1'b1;
                mode_d   = job_mode_d;
            end
            default: ;
        endcase
    end

    // The counter may only report a load while a load cycle is being driven
    a_load_consistent: assert property (@(posedge clk) disable iff (!reset)
        load_ |-> (enable_q && mode_q == MODE_LOAD));

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign result   = result_q;
    assign rco_seen = rco_seen_q;
    assign busy     = busy_q;
    assign enable_  = enable_q;
    assign mode_    = mode_q;
    assign D_       = dout_q;

endmodule

// File: tb/tb_cnt32_sched.sv
// Directed bench for cnt32_sched with a behavioural 32-bit counter attached.
module tb_cnt32_sched;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  mode0, mode1;
    logic [31:0] d0, d1;
    logic [7:0]  len0, len1;
    logic        pre0, pre1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] result;
    logic        rco_seen, busy;
    logic        enable_;
    logic [1:0]  mode_;
    logic [31:0] D_;
    logic [31:0] cnt_model = 32'h0;
    logic        rco_, load_;

    int n_tests = 0;
    int n_fail  = 0;

    cnt32_sched #(.WIDTH(32), .LEN_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
        .d0(d0), .d1(d1), .len0(len0), .len1(len1), .pre0(pre0), .pre1(pre1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .rco_seen(rco_seen), .busy(busy),
        .enable_(enable_), .mode_(mode_), .D_(D_),
        .Q_(cnt_model), .rco_(rco_), .load_(load_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter: 11 load, 00 up, 01 down, 10 hold
    always @(posedge clk) begin
        if (enable_) begin
            case (mode_)
                2'b11:   cnt_model <= D_;
                2'b00:   cnt_model <= cnt_model + 32'd1;
                2'b01:   cnt_model <= cnt_model - 32'd1;
                default: cnt_model <= cnt_model;
            endcase
        end
    end
    assign rco_  = enable_ && (mode_ == 2'b00) && (cnt_model == 32'hFFFF_FFFF);
    assign load_ = enable_ && (mode_ == 2'b11);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job to completion; reqs are dropped in the cycle done is seen
    task automatic observe(input int max_cyc, output int gnt_at, output int done_at,
                           output int en_cnt, output int run_cnt, output int g0, output int g1);
        gnt_at = 0; done_at = 0; en_cnt = 0; run_cnt = 0; g0 = 0; g1 = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (gnt0 || gnt1) gnt_at = i;
            if (gnt0) g0++;
            if (gnt1) g1++;
            if (enable_) en_cnt++;
            if (enable_ && mode_ == 2'b00) run_cnt++;
            if (done0 || done1) begin
                done_at = i;
                req0 = 1'b0;
                req1 = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_tests++;
        if ({enable_, mode_, D_} !== 35'h0) begin
            n_fail++; $display("FAIL reset_ctl: got en=%b mode=%b D=%h expected 0", enable_, mode_, D_);
        end
        n_tests++;
        if ({gnt0, gnt1, done0, done1, rco_seen, busy} !== 6'b0 || result !== 32'h0) begin
            n_fail++; $display("FAIL reset_out: got flags=%b result=%h expected 0",
                               {gnt0, gnt1, done0, done1, rco_seen, busy}, result);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_idle: got busy=%b gnt=%b%b expected 0", busy, gnt0, gnt1);
        end
    endtask

    task automatic test_contention();
        int gseq[4];
        int ng = 0, nd = 0, last_done = 0;
        mode0 = 2'b00; mode1 = 2'b00; pre0 = 1'b0; pre1 = 1'b0;
        len0 = 8'd2; len1 = 8'd2; d0 = 32'h0; d1 = 32'h0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (gnt0 || gnt1) begin
                if (ng < 4) gseq[ng] = gnt1 ? 1 : 0;
                ng++;
                if (last_done != 0) begin
                    n_tests++;
                    if (i - last_done !== 1) begin
                        n_fail++; $display("FAIL cont_gap: got %0d cycles done->gnt expected 1", i - last_done);
                    end
                end
            end
            if (done0 || done1) begin
                last_done = i;
                nd++;
                if (nd == 4) begin
                    req0 = 1'b0; req1 = 1'b0;
                    break;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_tests++;
        if (ng !== 4 || nd !== 4) begin
            n_fail++; $display("FAIL cont_count: got gnt=%0d done=%0d expected 4/4", ng, nd);
        end else begin
            n_tests++;
            if (gseq[0] !== 0 || gseq[1] !== 1 || gseq[2] !== 0 || gseq[3] !== 1) begin
                n_fail++; $display("FAIL cont_order: got %0d%0d%0d%0d expected 0101",
                                   gseq[0], gseq[1], gseq[2], gseq[3]);
            end
        end
        tick();
    endtask

    task automatic test_single_job();
        int ga, da, en, rn, g0, g1;
        req0 = 1'b1; pre0 = 1'b1; d0 = 32'h10; mode0 = 2'b00; len0 = 8'd5;
        tick();
        n_tests++;
        if (gnt0 !== 1'b1 || enable_ !== 1'b1 || mode_ !== 2'b11 || D_ !== 32'h10 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_load: got gnt0=%b en=%b mode=%b D=%h busy=%b expected 1 1 11 10 1",
                               gnt0, enable_, mode_, D_, busy);
        end
        observe(20, ga, da, en, rn, g0, g1);
        n_tests++;
        if (da !== 7) begin
            n_fail++; $display("FAIL single_done_cycle: got done at %0d expected 8", da + 1);
        end
        n_tests++;
        if (rn !== 5 || en !== 5 || g0 !== 0) begin
            n_fail++; $display("FAIL single_run: got run=%0d en=%0d extra_gnt=%0d expected 5 5 0", rn, en, g0);
        end
        n_tests++;
        if (result !== 32'h15) begin
            n_fail++; $display("FAIL single_result: got %h expected 00000015", result);
        end
        tick();
    endtask

    task automatic test_zero_len();
        int ga, da, en, rn, g0, g1;
        req1 = 1'b1; pre1 = 1'b0; len1 = 8'd0; mode1 = 2'b00; d1 = 32'h55;
        observe(10, ga, da, en, rn, g0, g1);
        n_tests++;
        if (ga !== 1 || da !== 2 || g1 !== 1 || g0 !== 0) begin
            n_fail++; $display("FAIL zero_timing: got gnt@%0d done@%0d g1=%0d g0=%0d expected 1 2 1 0",
                               ga, da, g1, g0);
        end
        n_tests++;
        if (en !== 0 || done1 !== 1'b1) begin
            n_fail++; $display("FAIL zero_enable: got en_cycles=%0d done1=%b expected 0 1", en, done1);
        end
        tick();
    endtask

    task automatic test_load_only();
        int ga, da, en, rn, g0, g1;
        req0 = 1'b1; pre0 = 1'b0; mode0 = 2'b11; d0 = 32'hFFFF_FFFE; len0 = 8'd9;
        observe(20, ga, da, en, rn, g0, g1);
        n_tests++;
        if (ga !== 1 || da !== 3 || en !== 1 || done0 !== 1'b1) begin
            n_fail++; $display("FAIL loadonly_timing: got gnt@%0d done@%0d en=%0d done0=%b expected 1 3 1 1",
                               ga, da, en, done0);
        end
        n_tests++;
        if (result !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL loadonly_result: got %h expected fffffffe", result);
        end
        tick();
    endtask

    task automatic test_wrap_rco();
        int ga, da, en, rn, g0, g1;
        req0 = 1'b1; pre0 = 1'b1; mode0 = 2'b00; d0 = 32'hFFFF_FFFD; len0 = 8'd6;
        observe(20, ga, da, en, rn, g0, g1);
        n_tests++;
        if (rco_seen !== 1'b1) begin
            n_fail++; $display("FAIL wrap_rco_seen: got %b expected 1", rco_seen);
        end
`ifdef CNT_SCHED_RCO_STOP_EN
        n_tests++;
        if (rn !== 3 || da !== 6) begin
            n_fail++; $display("FAIL wrap_run: got run=%0d done@%0d expected 3 6", rn, da);
        end
        n_tests++;
        if (result !== 32'h0) begin
            n_fail++; $display("FAIL wrap_result: got %h expected 00000000", result);
        end
`else
        n_tests++;
        if (rn !== 6 || da !== 9) begin
            n_fail++; $display("FAIL wrap_run: got run=%0d done@%0d expected 6 9", rn, da);
        end
        n_tests++;
        if (result !== 32'h3) begin
            n_fail++; $display("FAIL wrap_result: got %h expected 00000003", result);
        end
`endif
        tick();
        // Next grant must clear the sticky flag
        req1 = 1'b1; pre1 = 1'b0; len1 = 8'd1; mode1 = 2'b00;
        tick();
        n_tests++;
        if (gnt1 !== 1'b1 || rco_seen !== 1'b0) begin
            n_fail++; $display("FAIL rco_clear_on_gnt: got gnt1=%b rco_seen=%b expected 1 0", gnt1, rco_seen);
        end
        observe(10, ga, da, en, rn, g0, g1);
        tick();
    endtask

    task automatic test_mid_reset();
        int spurious = 0;
        req0 = 1'b1; pre0 = 1'b0; mode0 = 2'b00; len0 = 8'd20; d0 = 32'h0;
        repeat (3) tick();
        req0 = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || enable_ !== 1'b1) begin
            n_fail++; $display("FAIL midrst_running: got busy=%b en=%b expected 1 1", busy, enable_);
        end
        #3;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({enable_, mode_, D_} !== 35'h0 || busy !== 1'b0 || rco_seen !== 1'b0 || result !== 32'h0) begin
            n_fail++; $display("FAIL midrst_async: got en=%b mode=%b D=%h busy=%b rco=%b result=%h expected all 0",
                               enable_, mode_, D_, busy, rco_seen, result);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done0 || done1 || busy) spurious++;
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done0 || done1 || busy || gnt0 || gnt1) spurious++;
        end
        n_tests++;
        if (spurious !== 0) begin
            n_fail++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", spurious);
        end
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; mode0 = 2'b00; mode1 = 2'b00;
        d0 = 32'h0; d1 = 32'h0; len0 = 8'd0; len1 = 8'd0; pre0 = 1'b0; pre1 = 1'b0;
        test_reset();
        test_contention();
        test_single_job();
        test_zero_len();
        test_load_only();
        test_wrap_rco();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt32_sched.md
Name: cnt32_sched

Overview:
- Round-robin scheduler that shares the single 32-bit counter between two requesters and sequences each job: optional preload, N enabled count cycles, then result capture.
- Sits between two client blocks and the counter. It is the only driver of the counter's enable_, mode_ and D_ inputs.

Parameters:
WIDTH, 32, counter data width
LEN_W, 8, width of the per-job run-length field

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0, req1  input  1 each  job request, held high until matching done pulse
mode0, mode1  input  2 each  counter mode for the job (2'b11 = load)
d0, d1  input  WIDTH each  preload value
len0, len1  input  LEN_W each  number of enabled count cycles
pre0, pre1  input  1 each  perform load cycle before counting
gnt0, gnt1  output  1 each  one-cycle grant pulse
done0, done1  output  1 each  one-cycle completion pulse
result  output  WIDTH  counter Q captured at job end, held until next capture
rco_seen  output  1  sticky per job: rco_ observed during RUN
busy  output  1  high in LOAD/RUN/DONE
enable_  output  1  counter enable
mode_  output  2  counter mode
D_  output  WIDTH  counter load data
Q_  input  WIDTH  counter value
rco_  input  1  counter ripple-carry out
load_  input  1  counter load indication (monitor only)

Behaviour:
- All outputs registered. Reset (reset=0, async) forces IDLE with these values:
  - enable_=0, mode_=2'b00, D_=0
  - gnt*=0, done*=0, result=0, rco_seen=0, busy=0
  - last-served pointer=1, so req0 wins the first tie.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Sample req0/req1. If only one is high, select it. If both are high, select the one not last served.
  - Latch that requester's mode/d/len/pre into the job registers. Pulse its gnt on the next cycle.
  - Clear rco_seen on grant.
  - Next state: if pre=1 or mode=2'b11, go to LOAD; else if len=0, go to DONE; else go to RUN.
- LOAD (1 cycle): enable_=1, mode_=2'b11, D_=d.
  - Next state: if mode=2'b11 or len=0, go to DONE; else go to RUN.
- RUN:
  - enable_=1, mode_=job mode, D_ holds the last value.
  - Remaining count is loaded with len and decremented each cycle.
  - Exactly len cycles have enable_=1, then go to DONE.
  - If rco_=1 in any RUN cycle, set rco_seen=1.
- DONE (1 cycle):
  - enable_=0.
  - Capture result=Q_, which reflects the final enabled edge.
  - Pulse done of the served requester and update the last-served pointer. Return to IDLE.
- Latency: req sampled high in IDLE -> gnt 1 cycle later. Total job = 1 (grant) + pre + len + 1 (DONE) cycles.
- Requests arriving while busy wait; they are not lost as long as the requester holds req.
- A req that drops before grant is simply not served.
- A req still high in the IDLE cycle after done is treated as a new job. Clients must drop req on done.
- Job fields are latched at grant; later changes to them are ignored.
- len is unsigned; len = 2^LEN_W-1 is the maximum.
- Reset mid-job aborts the job immediately: no done, result unchanged from its reset value 0.

Optional Feature:
- Macro: CNT_SCHED_RCO_STOP_EN.
- Defined: the first cycle in RUN with rco_=1 sets rco_seen and ends RUN that cycle, so the next state is DONE and result captures Q_ as usual. Fewer than len enabled cycles may occur.
- Undefined: rco_ is only recorded in rco_seen; RUN always lasts len cycles.

Test Plan:
- Reset check: reset=0 at t=0, released after 3 clk; mid-RUN reset=0 -> all outputs return to reset values asynchronously; no done0/done1.
- Single job: req0=1, pre0=1, d0=32'h10, mode0=2'b00, len0=5 -> gnt0 pulse, 1 LOAD cycle with D_=32'h10, mode_=2'b11, 5 RUN cycles with enable_=1, done0 on cycle 8 after req; result equals the counter Q_ after those 5 cycles.
- Contention: req0=req1=1 continuously after reset -> grants alternate 0,1,0,1; each done precedes the next gnt by exactly 1 cycle.
- Zero length: req1=1, pre1=0, len1=0 -> gnt1, then done1 next cycle, enable_ never high.
- Load-only: mode0=2'b11, d0=32'hFFFF_FFFE, len0=9 -> one LOAD cycle, no RUN, done0 asserted, result=32'hFFFF_FFFE.
- Wrap/rco: preload 32'hFFFF_FFFD, mode0=2'b00, len0=6 -> rco_seen=1. Without the macro, 6 RUN cycles. With CNT_SCHED_RCO_STOP_EN, RUN ends on the rco_ cycle and result holds the wrapped value.
